// File: rtl/led_pulse_stretch.sv
// Stretches short event pulses into visible LED blinks. Events that arrive while
// a blink is running are queued and replayed one blink each; overflow is sticky.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  S_IDLE | LED off, nothing queued, waiting for an event
//  S_ON   | LED lit, counting ON_CYCLES
//  S_GAP  | LED off, counting OFF_CYCLES before the next queued blink
module led_pulse_stretch #(
  parameter int unsigned ON_CYCLES  = 12500000,
  parameter int unsigned OFF_CYCLES = 12500000,
  parameter int unsigned PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic              clr_ovf,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_trig_q;
  logic               r_led;
  logic [PEND_W-1:0]  r_pend;
  logic               r_ovf;

  logic w_evt;
  logic w_active;
  logic w_gap_end;
  logic w_pend_full;
  logic w_drop;

  assign w_evt       = trig & ~r_trig_q;
  assign w_active    = (r_state != S_IDLE);
  assign w_gap_end   = (r_state == S_GAP) && (r_cnt == OFF_LAST);
  assign w_pend_full = (r_pend == PEND_MAX);
  // An event coinciding with the gap-end decrement replaces the dequeued slot, so it is never dropped.
  assign w_drop      = w_evt & w_active & ~w_gap_end & w_pend_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_trig_q <= 1'b1;
      r_led    <= 1'b0;
      r_pend   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_trig_q <= trig;

      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_evt) begin
            r_state <= S_ON;
            r_cnt   <= '0;
            r_led   <= 1'b1;
          end
        end

        S_ON: begin
          if (r_cnt == ON_LAST) begin
            r_state <= S_GAP;
            r_cnt   <= '0;
            r_led   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
          if (w_evt && !w_pend_full) begin
            r_pend <= r_pend + 1'b1;
          end
        end

        S_GAP: begin
          if (w_gap_end) begin
            r_cnt <= '0;
            if ((r_pend != '0) || w_evt) begin
              r_state <= S_ON;
              r_led   <= 1'b1;
              if (!w_evt) begin
                r_pend <= r_pend - 1'b1;
              end
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
            if (w_evt && !w_pend_full) begin
              r_pend <= r_pend + 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_led   <= 1'b0;
        end
      endcase
    end
  end

  assign led      = r_led;
  assign busy     = w_active;
  assign pending  = r_pend;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Bench for led_pulse_stretch: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against an elapsed-time reference model.
module tb_led_pulse_stretch;

  localparam int ON   = 4;
  localparam int OFF  = 3;
  localparam int PW   = 2;
  localparam int MAXP = (1 << PW) - 1;

  logic          clk;
  logic          rst_n;
  logic          trig;
  logic          clr_ovf;
  logic          led;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int blinks  = 0;
  bit led_prev = 0;
  bit cmp_en = 0;

  led_pulse_stretch #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .PEND_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .clr_ovf(clr_ovf),
    .led(led), .busy(busy), .pending(pending), .overflow(overflow)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a blink is "active" with t cycles elapsed since it started.
  bit m_act  = 0;
  int m_t    = 0;
  int m_pend = 0;
  bit m_ovf  = 0;
  bit m_prev = 1;

  always @(posedge clk or negedge rst_n) begin
    bit evt, fin, drop;
    if (!rst_n) begin
      m_act = 0; m_t = 0; m_pend = 0; m_ovf = 0; m_prev = 1;
    end else begin
      evt = trig && !m_prev;
      m_prev = trig;
      drop = 0;
      if (!m_act) begin
        if (evt) begin m_act = 1; m_t = 0; end
      end else begin
        fin = (m_t == ON + OFF - 1);
        if (evt && !fin) begin
          if (m_pend == MAXP) drop = 1;
          else m_pend++;
        end
        if (fin) begin
          if (m_pend > 0 || evt) begin
            if (!evt) m_pend--;
            m_t = 0;
          end else begin
            m_act = 0;
          end
        end else begin
          m_t++;
        end
      end
      if (drop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_led", led, (m_act && m_t < ON) ? 1 : 0);
      chk("model_busy", busy, m_act ? 1 : 0);
      chk("model_pending", pending, m_pend);
      chk("model_overflow", overflow, m_ovf ? 1 : 0);
    end
    if (led && !led_prev) blinks++;
    led_prev = led;
  end

  task automatic pulse1();
    trig = 1;
    @(negedge clk);
    trig = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int b0;

  initial begin
    rst_n = 0; trig = 0; clr_ovf = 0;
    cycles(3);
    cmp_en = 1;
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1;
    cycles(5);

    // single pulse: led high 4 cycles, then 3 gap cycles, then idle
    pulse1();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("single_led_%0d", i), led, (i < 4) ? 1 : 0);
      chk($sformatf("single_busy_%0d", i), busy, (i < 7) ? 1 : 0);
      @(negedge clk);
    end
    cycles(3);

    // three queued events -> four blinks total
    b0 = blinks;
    pulse1();
    for (int k = 0; k < 3; k++) begin @(negedge clk); pulse1(); end
    chk("queue3_pending", pending, 3);
    cycles(40);
    chk("queue3_blinks", blinks - b0, 4);
    chk("queue3_pending_end", pending, 0);
    chk("queue3_overflow", overflow, 0);
    chk("queue3_busy_end", busy, 0);

    // saturation: overflow set wins over a simultaneous clear
    pulse1();
    for (int k = 0; k < 4; k++) begin @(negedge clk); pulse1(); end
    @(negedge clk);
    clr_ovf = 1;
    pulse1();
    clr_ovf = 0;
    chk("sat_overflow_set", overflow, 1);
    chk("sat_pending", pending, 3);
    clr_ovf = 1;
    @(negedge clk);
    clr_ovf = 0;
    chk("sat_overflow_clr", overflow, 0);
    cycles(40);

    // held level: exactly one blink
    b0 = blinks;
    trig = 1;
    cycles(50);
    chk("level_pending", pending, 0);
    trig = 0;
    cycles(20);
    chk("level_blinks", blinks - b0, 1);

    // reset during ON with pending=2, trig held across release
    pulse1();
    for (int k = 0; k < 3; k++) begin @(negedge clk); pulse1(); end
    @(negedge clk);
    chk("rst_on_led_before", led, 1);
    chk("rst_on_pending_before", pending, 2);
    trig = 1;
    #2 rst_n = 0;
    #1;
    chk("rst_on_led_async", led, 0);
    chk("rst_on_pending_async", pending, 0);
    chk("rst_on_busy_async", busy, 0);
    cycles(2);
    rst_n = 1;
    b0 = blinks;
    cycles(10);
    trig = 0;
    cycles(2);
    chk("rst_release_blinks", blinks - b0, 0);
    chk("rst_release_busy", busy, 0);

    // event in the last gap cycle with pending=1
    pulse1();
    @(negedge clk);
    pulse1();
    cycles(4);
    chk("gapend_pending_before", pending, 1);
    pulse1();
    chk("gapend_led", led, 1);
    chk("gapend_pending", pending, 1);
    cycles(30);

    // randomized traffic at varying densities with occasional resets and clears
    for (int seg = 0; seg < 6; seg++) begin
      int dens;
      dens = 1 + seg % 3;
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, dens) == 0) trig = ~trig;
        clr_ovf = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 399) == 0) begin
          #2 rst_n = 0;
          @(negedge clk);
          #2 rst_n = 1;
        end
        @(negedge clk);
      end
    end
    trig = 0; clr_ovf = 0;
    cycles(40);
    chk("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pulse_stretch.md
LED_PULSE_STRETCH -- requirements
Module: led_pulse_stretch

Interface
REQ-001 Parameter ON_CYCLES, default 12500000: LED-on duration per blink in clk cycles; legal range 1 or more.
REQ-002 Parameter OFF_CYCLES, default 12500000: minimum LED-off gap after each blink in clk cycles; legal range 1 or more.
REQ-003 Parameter PEND_W, default 4: width of the pending-event counter; legal range 1 or more.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low, ports clk and rst_n.
REQ-005 clk  input  1  system clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 trig  input  1  synchronous event request; each rising edge is one event.
REQ-008 clr_ovf  input  1  synchronous clear of overflow.
REQ-009 led  output  1  stretched, registered indicator drive.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 pending  output  PEND_W  count of events queued but not yet shown.
REQ-012 overflow  output  1  sticky flag: an event was dropped.

Function
REQ-013 Edge detect: trig_q SHALL be a register of trig, and the event SHALL be trig AND NOT trig_q.
REQ-014 FSM states SHALL be IDLE, ON and GAP. There SHALL be one 32-bit cycle counter, cleared on every state entry.
REQ-015 IDLE with an event in cycle N: the FSM SHALL enter ON at the clk edge ending cycle N, so led is high from cycle N+1.
REQ-016 ON SHALL last exactly ON_CYCLES cycles with led=1, then enter GAP.
REQ-017 GAP SHALL last exactly OFF_CYCLES cycles with led=0. At the end of GAP: if pending>0, decrement pending and enter ON; otherwise enter IDLE.
REQ-018 An event in ON or GAP SHALL increment pending, saturating at 2^PEND_W-1.
REQ-019 An event that arrives while pending is saturated SHALL be dropped and SHALL set overflow.
REQ-020 An event in the same cycle as the GAP-end decrement SHALL leave pending unchanged, and the next ON SHALL start.
REQ-021 clr_ovf=1 SHALL clear overflow on the next edge; if an overflow set occurs in the same cycle, the set SHALL win.
REQ-022 A level held high on trig SHALL produce exactly one event.
REQ-023 led SHALL be driven directly from a register, with no combinational path from trig.

Reset
REQ-024 Asserting rst_n=0 SHALL asynchronously force state=IDLE, counter=0, led=0, busy=0, pending=0 and overflow=0.
REQ-025 During reset, trig_q SHALL be forced to 1, so that trig held high across reset release produces no event.
REQ-026 A reset during ON or GAP SHALL abort the blink immediately and discard all queued events.

Structure
REQ-027 No shared package. State encoding and the counter width (32) SHALL be localparams inside the module.
REQ-028 No sub-module is needed; the edge detector SHALL be inline.
REQ-029 The block SHALL be instantiable once per board LED alongside the existing button debouncers.

Verification (ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2)
REQ-030 Single trig pulse high in cycle 10 -> led=1 in cycles 11-14, led=0 and busy=1 in cycles 15-17, busy=0 from cycle 18.
REQ-031 Three single-cycle pulses during the first ON -> pending reaches 3, exactly four blinks, then IDLE with pending=0 and overflow=0.
REQ-032 Four pulses during the first ON -> pending saturates at 3 and overflow=1. clr_ovf in the same cycle as the fourth pulse -> overflow stays 1. clr_ovf one cycle later -> overflow=0.
REQ-033 trig held high for 50 cycles -> exactly one blink, and pending stays 0.
REQ-034 rst_n low for 2 cycles during ON with pending=2 -> led=0 immediately and pending=0. trig held high across release -> no blink afterwards.
REQ-035 pending=1 and a new pulse in the last GAP cycle -> pending remains 1 and the next ON starts on the following cycle.
